// File: rtl/ccg_lut_eval.sv
// Programmable N_IN-input / N_OUT-output truth-table evaluator behind a valid/ready pipeline.
// Optional macro CCG_LUT_OUTREG_EN adds a second output register stage (latency 2).
module ccg_lut_eval #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [N_IN-1:0]  cfg_addr,
  input  logic [N_OUT-1:0] cfg_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_IN-1:0]  x,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_OUT-1:0] f,
  output logic [CNT_W-1:0] eval_cnt,
  output logic             clr_busy
);

  localparam int DEPTH = 1 << N_IN;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t           state, state_nxt;
  logic [N_IN-1:0]  idx, idx_nxt;
  logic [N_OUT-1:0] tbl [DEPTH];
  logic             adv;
  logic             accept;
  logic [N_OUT-1:0] lookup;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    clr_busy  = 1'b0;
    in_ready  = 1'b0;
    case (state)
      CLEAR: begin
        clr_busy = 1'b1;
        idx_nxt  = idx + 1'b1;
        if (&idx) state_nxt = RUN;
      end
      RUN: begin
        in_ready = adv;
      end
      default: state_nxt = CLEAR;
    endcase
  end

  // The clear sweep owns the write port; configuration writes only land in RUN.
  always_ff @(posedge clk) begin
    if (state == CLEAR)
      tbl[idx] <= '0;
    else if (cfg_we)
      tbl[cfg_addr] <= cfg_data;
  end

  assign adv    = !out_valid || out_ready;
  assign accept = in_valid && in_ready;
  assign lookup = tbl[x];

  // Stage p0: table lookup result
  logic             vld_p0;
  logic [N_OUT-1:0] f_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      f_p0   <= '0;
    end else if (adv) begin
      vld_p0 <= accept;
      if (accept) f_p0 <= lookup;
    end
  end

`ifdef CCG_LUT_OUTREG_EN
  // Stage p1: output register, advances in lockstep with p0
  logic             vld_p1;
  logic [N_OUT-1:0] f_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      f_p1   <= '0;
    end else if (adv) begin
      vld_p1 <= vld_p0;
      f_p1   <= f_p0;
    end
  end

  assign out_valid = vld_p1;
  assign f         = f_p1;
`else
  assign out_valid = vld_p0;
  assign f         = f_p0;
`endif

  always_ff @(posedge clk) begin
    if (rst)
      eval_cnt <= '0;
    else if (out_valid && out_ready)
      eval_cnt <= sat_inc(eval_cnt);
  end

endmodule
